// File: rtl/rr_arbiter4_if.sv
// Grant bus between four clients and the round-robin arbiter.
// The master modport belongs to the arbiter, and the slave modport belongs to the client side.
interface rr_arbiter4_if;
    // Handshake: a client raises req[i] and holds it for as long as it needs the resource.
    // A client owns the resource while gnt[i]=1, and it releases the resource by dropping req[i].
    // The arbiter changes grants only on clock edges. It never takes a grant from an owner that
    // is still requesting, except when the hold-limit option forces a rotation.
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       hold_expired;

    modport master (input req, output gnt, gnt_idx, gnt_valid, hold_expired);
    modport slave  (output req, input gnt, gnt_idx, gnt_valid, hold_expired);
endinterface

// File: rtl/rr_arbiter4.sv
// 4-client round-robin arbiter with a registered one-hot grant and a binary index.
// Define ARB_HOLD_LIMIT_EN to force a rotation after MAX_HOLD consecutive grant cycles.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    rr_arbiter4_if.master     bus,
    output logic              dbg_state,
    output logic [1:0]        dbg_ptr
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_cfg
        $error("rr_arbiter4: illegal MAX_HOLD/CNT_W combination");
    end

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] owner_nxt;
    logic [2:0] from_ptr, from_nxt;

    // Returns {found, index} for the first requester at s, s+1, s+2, s+3 (mod 4).
    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] s);
        logic [1:0] c;
        search = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            c = s + k[1:0];
            if (r[c]) search = {1'b1, c};
        end
    endfunction

`ifdef ARB_HOLD_LIMIT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             he_q, he_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        owner_nxt = idx_q + 2'd1;
        from_ptr  = search(bus.req, ptr_q);
        from_nxt  = search(bus.req, owner_nxt);
`ifdef ARB_HOLD_LIMIT_EN
        cnt_d     = cnt_q;
        he_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (from_ptr[2]) begin
                    gnt_d   = 4'b0001 << from_ptr[1:0];
                    idx_d   = from_ptr[1:0];
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A release hands the grant straight to the next requester, so no idle bubble occurs.
                if (!bus.req[idx_q]) begin
                    ptr_d = owner_nxt;
`ifdef ARB_HOLD_LIMIT_EN
                    cnt_d = '0;
`endif
                    if (from_nxt[2]) begin
                        gnt_d = 4'b0001 << from_nxt[1:0];
                        idx_d = from_nxt[1:0];
                    end else begin
                        gnt_d   = 4'b0000;
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
`ifdef ARB_HOLD_LIMIT_EN
                // The owner is still requesting here, so the search always finds a client (possibly the owner).
                else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    ptr_d = owner_nxt;
                    cnt_d = '0;
                    gnt_d = 4'b0001 << from_nxt[1:0];
                    idx_d = from_nxt[1:0];
                    he_d  = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= '0;
            he_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_q   <= cnt_d;
            he_q    <= he_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = |gnt_q;
`ifdef ARB_HOLD_LIMIT_EN
    assign bus.hold_expired = he_q;
`else
    assign bus.hold_expired = 1'b0;
`endif
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: reset, rotation, skip, async reset, and hold behaviour.
// Expected grant words are queued as each request step is driven and checked after the edge.
module tb_rr_arbiter4;
    logic       clk = 1'b0;
    logic       rst;
    logic       dbg_state;
    logic [1:0] dbg_ptr;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    rr_arbiter4_if bus ();

    rr_arbiter4 dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: enc = 2'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drives one request word across a rising edge and compares the queued expectation.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] g, input logic he);
        logic [7:0] e;
        exp_q.push_back({he, |g, enc(g), g});
        bus.req = r;
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".gnt"},   {4'b0, bus.gnt},          {4'b0, e[3:0]});
        check({tag, ".idx"},   {6'b0, bus.gnt_idx},      {6'b0, e[5:4]});
        check({tag, ".valid"}, {7'b0, bus.gnt_valid},    {7'b0, e[6]});
        check({tag, ".hexp"},  {7'b0, bus.hold_expired}, {7'b0, e[7]});
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"},   {4'b0, bus.gnt},          8'h00);
        check({tag, ".idx"},   {6'b0, bus.gnt_idx},      8'h00);
        check({tag, ".valid"}, {7'b0, bus.gnt_valid},    8'h00);
        check({tag, ".hexp"},  {7'b0, bus.hold_expired}, 8'h00);
    endtask

    task automatic do_reset(input string tag, input logic [3:0] r);
        @(negedge clk);
        rst     = 1'b1;
        bus.req = r;
        @(posedge clk);
        @(negedge clk);
        check_idle(tag);
        check({tag, ".ptr"},   {6'b0, dbg_ptr}, 8'h00);
        check({tag, ".state"}, {7'b0, dbg_state}, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;

        // T1: reset holds everything low even with all requests up.
        do_reset("t1_rst", 4'b1111);
        step("t1_first", 4'b1111, 4'b0001, 1'b0);
        check("t1_state", {7'b0, dbg_state}, 8'h01);

        // T2: each owner drops its request two cycles after its grant.
        step("t2_hold0", 4'b1111, 4'b0001, 1'b0);
        step("t2_to1",   4'b1110, 4'b0010, 1'b0);
        step("t2_hold1", 4'b1111, 4'b0010, 1'b0);
        step("t2_to2",   4'b1101, 4'b0100, 1'b0);
        step("t2_hold2", 4'b1111, 4'b0100, 1'b0);
        step("t2_to3",   4'b1011, 4'b1000, 1'b0);
        step("t2_hold3", 4'b1111, 4'b1000, 1'b0);
        step("t2_wrap",  4'b0111, 4'b0001, 1'b0);
        step("t2_idle",  4'b0000, 4'b0000, 1'b0);
        check("t2_ptr",   {6'b0, dbg_ptr},   8'h01);
        check("t2_state", {7'b0, dbg_state}, 8'h00);

        // T3: single requester from IDLE, then release.
        step("t3_grant", 4'b0100, 4'b0100, 1'b0);
        step("t3_rel",   4'b0000, 4'b0000, 1'b0);
        check("t3_ptr", {6'b0, dbg_ptr}, 8'h03);

        // T4: client 2 is not requesting and is skipped after client 1 releases.
        do_reset("t4_rst", 4'b0000);
        step("t4_grant", 4'b1010, 4'b0010, 1'b0);
        step("t4_hold",  4'b1010, 4'b0010, 1'b0);
        step("t4_skip",  4'b1000, 4'b1000, 1'b0);
        step("t4_rel",   4'b0000, 4'b0000, 1'b0);
        check("t4_ptr", {6'b0, dbg_ptr}, 8'h00);

        // T5: move ptr to 3, grant client 2, then reset between edges.
        step("t5_a",     4'b0100, 4'b0100, 1'b0);
        step("t5_b",     4'b0000, 4'b0000, 1'b0);
        check("t5_ptr3", {6'b0, dbg_ptr}, 8'h03);
        step("t5_grant", 4'b0100, 4'b0100, 1'b0);
        #1 rst = 1'b1;
        #1 check_idle("t5_async");
        check("t5_ptr0", {6'b0, dbg_ptr}, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        step("t5_restart", 4'b1001, 4'b0001, 1'b0);

        // T6: two clients hold their requests continuously.
        do_reset("t6_rst", 4'b0000);
`ifdef ARB_HOLD_LIMIT_EN
        for (int i = 0; i < 8; i++) step("t6_own0", 4'b0011, 4'b0001, 1'b0);
        step("t6_rot1", 4'b0011, 4'b0010, 1'b1);
        for (int i = 0; i < 7; i++) step("t6_own1", 4'b0011, 4'b0010, 1'b0);
        step("t6_rot0",   4'b0011, 4'b0001, 1'b1);
        step("t6_after",  4'b0011, 4'b0001, 1'b0);
        step("t6_rel",    4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) step("t6_solo", 4'b0100, 4'b0100, 1'b0);
        step("t6_regrant", 4'b0100, 4'b0100, 1'b1);
        step("t6_solo2",   4'b0100, 4'b0100, 1'b0);
`else
        for (int i = 0; i < 100; i++) step("t6_hold", 4'b0011, 4'b0001, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
